// File: rtl/ifu_cache_ctrl.sv
// ifu_cache_ctrl: instruction-cache control FSM for the IFU.
//
// Holds a fully-associative tag/valid store (no data array; the external data
// array is indexed by rsp_way). A fetch request is latched in IDLE, looked up
// for one cycle, and either answered from a hit or filled from memory into the
// victim way offered by the PLRU. The controller drives the PLRU's hit/miss
// indication, hit way and update strobes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     fetch request handshake, req_addr is the byte address
//   rsp_valid           one-cycle response pulse with rsp_hit and rsp_way
//   mem_req_valid/ready line fill request, mem_req_addr is line-aligned
//   mem_rsp_valid       fill data written to the external data array
//   flush               level request to invalidate all ways (IDLE only)
//   cache_ctrl2_plru    PLRU strobes: [1] update_counter, [0] update_tree
//   cache_miss, hit_cl  miss indication and hit way to the PLRU
//   evicted_cl          victim way from the PLRU (combinational on cache_miss)

module ifu_cache_ctrl #(
  parameter int unsigned WAYS_NUM = 16,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 4,
  localparam int unsigned WAY_W   = $clog2(WAYS_NUM),
  localparam int unsigned TAG_W   = ADDR_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,

  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [WAY_W-1:0]  rsp_way,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,

  input  logic              flush,

  output logic [1:0]        cache_ctrl2_plru,
  output logic              cache_miss,
  output logic [WAY_W-1:0]  hit_cl,
  input  logic [WAY_W-1:0]  evicted_cl
);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissWait,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0]    req_tag_q;
  logic [WAY_W-1:0]    way_q;
  logic                hit_q;
  logic [WAYS_NUM-1:0] valid_q;
  logic [TAG_W-1:0]    tags_q [WAYS_NUM];

  logic                lookup_hit;
  logic [WAY_W-1:0]    lookup_way;
  logic                latch_req;
  logic                fill;
  logic                flush_all;

  // Only the line tag is kept; the byte offset has no use in a tag store.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  // Descending scan so the lowest matching way wins.
  always_comb begin
    lookup_hit = 1'b0;
    lookup_way = '0;
    for (int i = WAYS_NUM - 1; i >= 0; i--) begin
      if (valid_q[i] && (tags_q[i] == req_tag_q)) begin
        lookup_hit = 1'b1;
        lookup_way = WAY_W'(i);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_hit          = 1'b0;
    rsp_way          = '0;
    mem_req_valid    = 1'b0;
    mem_req_addr     = '0;
    cache_miss       = 1'b0;
    hit_cl           = '0;
    cache_ctrl2_plru = 2'b00;
    latch_req        = 1'b0;
    fill             = 1'b0;
    flush_all        = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = !flush;
        if (flush) begin
          flush_all = 1'b1;
        end else if (req_valid) begin
          latch_req = 1'b1;
          state_d   = StLookup;
        end
      end

      StLookup: begin
        if (lookup_hit) begin
          hit_cl           = lookup_way;
          cache_ctrl2_plru = 2'b11;
          state_d          = StResp;
        end else begin
          cache_miss = 1'b1;
          state_d    = StMissReq;
        end
      end

      StMissReq: begin
        cache_miss    = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag_q, {OFFSET_W{1'b0}}};
        if (mem_req_ready) begin
          state_d = StMissWait;
        end
      end

      StMissWait: begin
        cache_miss = 1'b1;
        if (mem_rsp_valid) begin
          fill             = 1'b1;
          cache_ctrl2_plru = 2'b11;
          state_d          = StResp;
        end
      end

      StResp: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        rsp_way   = way_q;
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      req_tag_q <= '0;
      way_q     <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        req_tag_q <= req_addr[ADDR_W-1:OFFSET_W];
      end
      // The victim is sampled in LOOKUP while cache_miss selects it in the PLRU.
      if (state_q == StLookup) begin
        hit_q <= lookup_hit;
        way_q <= lookup_hit ? lookup_way : evicted_cl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < WAYS_NUM; i++) begin
        tags_q[i] <= '0;
      end
    end else begin
      if (flush_all) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[way_q] <= 1'b1;
        tags_q[way_q]  <= req_tag_q;
      end
    end
  end

  // PLRU state cannot move between LOOKUP and the fill, so its victim must hold.
  victim_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q == StMissWait) && mem_rsp_valid) |-> (evicted_cl == way_q));

endmodule

// File: tb/tb_ifu_cache_ctrl.sv
module tb_ifu_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [3:0]  rsp_way;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic        flush;
  logic [1:0]  cache_ctrl2_plru;
  logic        cache_miss;
  logic [3:0]  hit_cl;
  logic [3:0]  evicted_cl;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ifu_cache_ctrl #(
    .WAYS_NUM(16),
    .ADDR_W  (32),
    .OFFSET_W(4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .rsp_valid       (rsp_valid),
    .rsp_hit         (rsp_hit),
    .rsp_way         (rsp_way),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .flush           (flush),
    .cache_ctrl2_plru(cache_ctrl2_plru),
    .cache_miss      (cache_miss),
    .hit_cl          (hit_cl),
    .evicted_cl      (evicted_cl)
  );

  // ---------------- reference model: cache contents + PLRU ----------------
  logic [27:0] m_tag [16];
  bit          m_valid [16];
  bit          tree [16];      // heap-indexed nodes 1..15, 1 = LRU side is right
  int          fill_cnt;
  logic [3:0]  vic;

  assign evicted_cl = cache_miss ? vic : 4'd0;

  function automatic logic [3:0] tree_victim();
    int node = 1;
    logic [3:0] v = 4'd0;
    for (int l = 0; l < 4; l++) begin
      v    = {v[2:0], tree[node]};
      node = node * 2 + int'(tree[node]);
    end
    return v;
  endfunction

  task automatic refresh_vic();
    vic = (fill_cnt < 16) ? 4'(fill_cnt) : tree_victim();
  endtask

  task automatic plru_touch(input logic [3:0] w);
    int node = 1;
    for (int l = 3; l >= 0; l--) begin
      tree[node] = ~w[l];
      node = node * 2 + int'(w[l]);
    end
    refresh_vic();
  endtask

  task automatic plru_fill(input logic [3:0] w);
    if (fill_cnt < 16) fill_cnt++;
    plru_touch(w);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      tree[i]    = 1'b0;
    end
    fill_cnt = 0;
    refresh_vic();
  endtask

  function automatic int find_way(input logic [27:0] t);
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_tag[i] == t) return i;
    end
    return -1;
  endfunction

  // ---------------- expected outputs for the current cycle ----------------
  bit          check_en = 1'b0;
  logic        exp_req_ready, exp_rsp_valid, exp_rsp_hit, exp_mem_req_valid, exp_cache_miss;
  logic [3:0]  exp_rsp_way, exp_hit_cl;
  logic [31:0] exp_mem_addr;
  logic [1:0]  exp_strobe;
  logic        last_hit;
  logic [3:0]  last_way;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_exp_busy();
    exp_req_ready     = 1'b0;
    exp_rsp_valid     = 1'b0;
    exp_rsp_hit       = 1'b0;
    exp_rsp_way       = '0;
    exp_mem_req_valid = 1'b0;
    exp_mem_addr      = '0;
    exp_cache_miss    = 1'b0;
    exp_hit_cl        = '0;
    exp_strobe        = 2'b00;
  endtask

  task automatic set_exp_idle();
    set_exp_busy();
    exp_req_ready = ~flush;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("req_ready", req_ready, exp_req_ready);
      check("rsp_valid", rsp_valid, exp_rsp_valid);
      check("mem_req_valid", mem_req_valid, exp_mem_req_valid);
      check("cache_miss", cache_miss, exp_cache_miss);
      check("hit_cl", hit_cl, exp_hit_cl);
      check("plru_strobe", cache_ctrl2_plru, exp_strobe);
      if (exp_rsp_valid) begin
        check("rsp_hit", rsp_hit, exp_rsp_hit);
        check("rsp_way", rsp_way, exp_rsp_way);
      end
      if (exp_mem_req_valid) check("mem_req_addr", mem_req_addr, exp_mem_addr);
      if (rsp_valid) begin
        last_hit = rsp_hit;
        last_way = rsp_way;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_idle();
    req_valid     = 1'b0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    set_exp_idle();
  endtask

  // One fetch transaction, scripted cycle by cycle from the request timing rules.
  task automatic do_req(input logic [31:0] addr, input int ready_lo, input int wait_cyc,
                        input bit abort_in_wait);
    logic [27:0] t;
    logic [3:0]  v;
    int          w;
    t = addr[31:4];
    // IDLE: request accepted at the coming edge
    flush = 1'b0; req_valid = 1'b1; req_addr = addr;
    mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom);
    set_exp_idle();
    step();
    // LOOKUP: further requester/memory activity must be ignored
    req_valid = 1'($urandom); req_addr = $urandom; flush = 1'($urandom);
    mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom);
    set_exp_busy();
    w = find_way(t);
    if (w >= 0) begin
      exp_hit_cl = w[3:0];
      exp_strobe = 2'b11;
      step();
      plru_touch(w[3:0]);
      set_exp_busy();
      exp_rsp_valid = 1'b1; exp_rsp_hit = 1'b1; exp_rsp_way = w[3:0];
      flush = 1'($urandom); mem_rsp_valid = 1'($urandom);
      step();
    end else begin
      v = vic;
      exp_cache_miss = 1'b1;
      step();
      for (int i = 0; i <= ready_lo; i++) begin
        mem_req_ready = (i == ready_lo);
        mem_rsp_valid = 1'($urandom);
        flush = 1'($urandom);
        set_exp_busy();
        exp_cache_miss = 1'b1; exp_mem_req_valid = 1'b1; exp_mem_addr = {t, 4'h0};
        step();
      end
      if (abort_in_wait) begin
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; flush = 1'b0; req_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        set_exp_idle();
        #1;
        check("reset_abort_mem_req_valid", mem_req_valid, 1'b0);
        check("reset_abort_cache_miss", cache_miss, 1'b0);
        check("reset_abort_req_ready", req_ready, 1'b1);
        step();
        step();
        rst_n = 1'b1;
        return;
      end
      for (int i = 0; i <= wait_cyc; i++) begin
        mem_rsp_valid = (i == wait_cyc);
        mem_req_ready = 1'($urandom);
        flush = 1'($urandom);
        set_exp_busy();
        exp_cache_miss = 1'b1;
        if (i == wait_cyc) exp_strobe = 2'b11;
        step();
      end
      m_tag[v] = t;
      m_valid[v] = 1'b1;
      plru_fill(v);
      set_exp_busy();
      exp_rsp_valid = 1'b1; exp_rsp_hit = 1'b0; exp_rsp_way = v;
      mem_rsp_valid = 1'($urandom); flush = 1'($urandom);
      step();
    end
    quiet_idle();
  endtask

  task automatic do_flush();
    flush = 1'b1; req_valid = 1'b1; req_addr = $urandom;
    set_exp_idle();
    step();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    quiet_idle();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      quiet_idle();
      step();
    end
    quiet_idle();
  endtask

  int ev;

  initial begin
    rst_n = 1'b0;
    req_addr = '0;
    quiet_idle();
    model_reset();
    check_en = 1'b1;
    #2;
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_mem_req_valid", mem_req_valid, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    idle_cycles(1);

    // Cold misses fill ways in order
    for (int k = 0; k < 4; k++) begin
      do_req(32'(k * 16), k, k, 1'b0);
      check("cold_fill_hit", last_hit, 1'b0);
      check("cold_fill_way", last_way, 32'(k));
    end

    // Hit on a line filled above
    do_req(32'h024, 0, 0, 1'b0);
    check("hit_024_flag", last_hit, 1'b1);
    check("hit_024_way", last_way, 32'd2);

    // Fill request backpressured for 5 cycles, response 3 cycles later
    do_req(32'h040, 5, 3, 1'b0);
    check("stall_fill_way", last_way, 32'd4);

    // Fill the remaining ways, touch way 0, then force a tree eviction
    for (int k = 5; k < 16; k++) do_req(32'(k * 16), $urandom_range(0, 2),
                                          $urandom_range(0, 2), 1'b0);
    do_req(32'h000, 0, 0, 1'b0);
    check("hit_way0", last_way, 32'd0);
    do_req(32'h100, 1, 1, 1'b0);
    check("evict_not_way0", 32'(last_way != 4'd0), 32'd1);
    ev = int'(last_way);
    do_req(32'(ev * 16), 0, 0, 1'b0);
    check("evicted_line_misses", last_hit, 1'b0);

    // Flush invalidates everything
    do_flush();
    do_req(32'h000, 0, 1, 1'b0);
    check("post_flush_miss", last_hit, 1'b0);

    // Reset while waiting for fill data
    do_req(32'h300, 0, 0, 1'b1);
    idle_cycles(1);
    do_req(32'h300, 0, 0, 1'b0);
    check("post_reset_miss", last_hit, 1'b0);
    check("post_reset_way", last_way, 32'd0);

    // Random traffic over a pool larger than the cache
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) do_flush();
      else do_req({$urandom_range(0, 23), 4'($urandom)}, $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'b0);
      idle_cycles($urandom_range(0, 2));
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
